// File: rtl/alu_types.sv
// Shared types for the RV32I decode stage.
//   alu_op_t      : ALU operation select driven straight into the execute ALU
//   src_a_sel_t   : operand A steering (RS1 / PC / ZERO)
//   src_b_sel_t   : operand B steering (RS2 / IMM / FOUR)
//   inst_class_t  : coarse instruction class for the execute stage
//   OPC_*         : RV32I major opcodes (instr[6:0])
//   decode_t      : one decoded entry, carries every out_* data field
package alu_types;

    localparam int unsigned XLEN_PKG = 32;

    typedef enum logic [3:0] {
        ALU_NOP     = 4'd0,
        ALU_ADD     = 4'd1,
        ALU_SUB     = 4'd2,
        ALU_SLL     = 4'd3,
        ALU_SLT     = 4'd4,
        ALU_SLTU    = 4'd5,
        ALU_XOR     = 4'd6,
        ALU_SRL     = 4'd7,
        ALU_SRA     = 4'd8,
        ALU_OR      = 4'd9,
        ALU_AND     = 4'd10,
        ALU_INVALID = 4'd15
    } alu_op_t;

    typedef enum logic [1:0] {
        SRC_A_RS1  = 2'd0,
        SRC_A_PC   = 2'd1,
        SRC_A_ZERO = 2'd2
    } src_a_sel_t;

    typedef enum logic [1:0] {
        SRC_B_RS2  = 2'd0,
        SRC_B_IMM  = 2'd1,
        SRC_B_FOUR = 2'd2
    } src_b_sel_t;

    typedef enum logic [2:0] {
        CLS_ALU    = 3'd0,
        CLS_LOAD   = 3'd1,
        CLS_STORE  = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_JUMP   = 3'd4,
        CLS_SYSTEM = 3'd5
    } inst_class_t;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef struct packed {
        logic [XLEN_PKG-1:0] pc;
        alu_op_t             alu_op;
        src_a_sel_t          a_sel;
        src_b_sel_t          b_sel;
        logic [XLEN_PKG-1:0] imm;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        inst_class_t         cls;
        logic                illegal;
    } decode_t;

    // Register-register funct3 mapping; alt selects SUB/SRA (funct7 bit 5).
    function automatic alu_op_t f3_to_alu(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_skid_buf.sv
// Generic 2-entry skid buffer (EMPTY/ONE/FULL), strictly FIFO.
//   clk, rst       : clock, async active-high reset
//   flush_i        : drop all entries, wins over push and pop
//   push_i, data_i : upstream offer; accepted only while ready_o
//   ready_o        : registered, low only when FULL
//   valid_o, data_o: oldest entry; pop_i consumes it
module decode_skid_buf
    import alu_types::*;
#(
    parameter type T = decode_t
) (
    input  logic clk,
    input  logic rst,
    input  logic flush_i,
    input  logic push_i,
    input  T     data_i,
    output logic ready_o,
    output logic valid_o,
    input  logic pop_i,
    output T     data_o
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t state_q;
    T       out_q;
    T       skid_q;
    logic   valid_q;
    logic   ready_q;
    logic   push;
    logic   pop;

    assign push    = push_i && ready_q;
    assign pop     = valid_q && pop_i;
    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign data_o  = out_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else if (flush_i) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        out_q   <= data_i;
                        valid_q <= 1'b1;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        skid_q  <= data_i;
                        ready_q <= 1'b0;
                        state_q <= FULL;
                    end else if (push) begin
                        out_q <= data_i;
                    end else if (pop) begin
                        valid_q <= 1'b0;
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        out_q   <= skid_q;
                        ready_q <= 1'b1;
                        state_q <= ONE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_decode_stage.sv
// RV32I decode stage: turns {pc, instr} into ALU select, operand steering,
// immediate, register indices and class, buffered through a 2-entry skid
// buffer so in_ready is registered and back-to-back transfers are sustained.
//   clk, rst, flush                 : clock, async reset, buffer flush
//   in_valid/in_ready/in_pc/in_instr: fetch side handshake
//   out_valid/out_ready             : execute side handshake
//   out_pc, out_alu_sel, out_a_sel, out_b_sel, out_imm,
//   out_rs1, out_rs2, out_rd, out_class, out_illegal : decoded entry
// XLEN must match alu_types::XLEN_PKG, which sizes decode_t.
module alu_decode_stage
    import alu_types::*;
#(
    parameter int unsigned XLEN               = XLEN_PKG,
    parameter bit          ILLEGAL_AS_INVALID = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [3:0]      out_alu_sel,
    output logic [1:0]      out_a_sel,
    output logic [1:0]      out_b_sel,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_class,
    output logic            out_illegal
);

    decode_t            dec;
    decode_t            buf_q;
    logic               bad;
    logic [6:0]         opc;
    logic [2:0]         f3;
    logic [6:0]         f7;
    logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opc   = in_instr[6:0];
    assign f3    = in_instr[14:12];
    assign f7    = in_instr[31:25];
    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'b0};
    assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    always_comb begin
        dec        = '0;
        bad        = 1'b0;
        dec.pc     = XLEN_PKG'(in_pc);
        dec.rs1    = in_instr[19:15];
        dec.rs2    = in_instr[24:20];
        dec.rd     = in_instr[11:7];
        dec.alu_op = ALU_ADD;
        dec.a_sel  = SRC_A_RS1;
        dec.b_sel  = SRC_B_RS2;
        dec.cls    = CLS_ALU;
        case (opc)
            OPC_OP: begin
                if (f7 == 7'b0000000)
                    dec.alu_op = f3_to_alu(f3, 1'b0);
                else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
                    dec.alu_op = f3_to_alu(f3, 1'b1);
                else
                    bad = 1'b1;
            end
            OPC_OP_IMM: begin
                dec.b_sel = SRC_B_IMM;
                dec.imm   = XLEN_PKG'(imm_i);
                // funct7 only qualifies the shift forms; elsewhere it is immediate
                if (f3 == 3'b001)
                    bad = (f7 != 7'b0000000);
                if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000)
                    bad = 1'b1;
                dec.alu_op = f3_to_alu(f3, (f3 == 3'b101) && f7[5]);
            end
            OPC_LUI: begin
                dec.a_sel = SRC_A_ZERO;
                dec.b_sel = SRC_B_IMM;
                dec.imm   = XLEN_PKG'(imm_u);
            end
            OPC_AUIPC: begin
                dec.a_sel = SRC_A_PC;
                dec.b_sel = SRC_B_IMM;
                dec.imm   = XLEN_PKG'(imm_u);
            end
            OPC_LOAD: begin
                dec.b_sel = SRC_B_IMM;
                dec.imm   = XLEN_PKG'(imm_i);
                dec.cls   = CLS_LOAD;
            end
            OPC_STORE: begin
                dec.b_sel = SRC_B_IMM;
                dec.imm   = XLEN_PKG'(imm_s);
                dec.cls   = CLS_STORE;
                dec.rd    = '0;
            end
            OPC_BRANCH: begin
                dec.imm = XLEN_PKG'(imm_b);
                dec.cls = CLS_BRANCH;
                dec.rd  = '0;
                case (f3[2:1])
                    2'b00:   dec.alu_op = ALU_SUB;
                    2'b10:   dec.alu_op = ALU_SLT;
                    2'b11:   dec.alu_op = ALU_SLTU;
                    default: bad = 1'b1;
                endcase
            end
            OPC_JAL: begin
                dec.a_sel = SRC_A_PC;
                dec.b_sel = SRC_B_FOUR;
                dec.imm   = XLEN_PKG'(imm_j);
                dec.cls   = CLS_JUMP;
            end
            OPC_JALR: begin
                dec.a_sel = SRC_A_PC;
                dec.b_sel = SRC_B_FOUR;
                dec.imm   = XLEN_PKG'(imm_i);
                dec.cls   = CLS_JUMP;
                bad       = (f3 != 3'b000);
            end
            OPC_MISC_MEM, OPC_SYSTEM: begin
                dec.alu_op = ALU_NOP;
                dec.imm    = XLEN_PKG'(imm_i);
                dec.cls    = CLS_SYSTEM;
            end
            // all legal opcodes end in 2'b11, so instr[1:0]!=11 lands here too
            default: bad = 1'b1;
        endcase
        if (bad) begin
            dec.alu_op  = ALU_INVALID;
            dec.a_sel   = SRC_A_RS1;
            dec.b_sel   = SRC_B_RS2;
            dec.imm     = '0;
            dec.cls     = CLS_ALU;
            dec.rd      = in_instr[11:7];
            dec.illegal = 1'b1;
        end
    end

    decode_skid_buf #(.T(decode_t)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        // dropped illegal instructions still complete the input handshake
        .push_i  (in_valid && (!dec.illegal || ILLEGAL_AS_INVALID)),
        .data_i  (dec),
        .ready_o (in_ready),
        .valid_o (out_valid),
        .pop_i   (out_ready),
        .data_o  (buf_q)
    );

    assign out_pc      = XLEN'(buf_q.pc);
    assign out_alu_sel = buf_q.alu_op;
    assign out_a_sel   = buf_q.a_sel;
    assign out_b_sel   = buf_q.b_sel;
    assign out_imm     = XLEN'(buf_q.imm);
    assign out_rs1     = buf_q.rs1;
    assign out_rs2     = buf_q.rs2;
    assign out_rd      = buf_q.rd;
    assign out_class   = buf_q.cls;
    assign out_illegal = buf_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
module tb_alu_decode_stage;
    import alu_types::*;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  alu;
        logic [1:0]  a;
        logic [1:0]  b;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  cls;
        logic        ill;
    } rec_t;

    typedef struct {
        logic [31:0] instr;
        rec_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_pc, in_instr;

    logic        rdy1, val1, ill1, rdy0, val0, ill0;
    logic [31:0] pc1, imm1, pc0, imm0;
    logic [3:0]  alu1, alu0;
    logic [1:0]  a1, b1, a0, b0;
    logic [4:0]  rs1_1, rs2_1, rd_1, rs1_0, rs2_0, rd_0;
    logic [2:0]  cls1, cls0;
    rec_t        act1, act0;

    int errors = 0;
    int checks = 0;
    rec_t q1[$];
    rec_t q0[$];
    bit last_x1;

    always #5 clk = ~clk;

    alu_decode_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy1), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(val1), .out_ready(out_ready), .out_pc(pc1),
        .out_alu_sel(alu1), .out_a_sel(a1), .out_b_sel(b1), .out_imm(imm1),
        .out_rs1(rs1_1), .out_rs2(rs2_1), .out_rd(rd_1),
        .out_class(cls1), .out_illegal(ill1)
    );

    alu_decode_stage #(.ILLEGAL_AS_INVALID(1'b0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy0), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(val0), .out_ready(out_ready), .out_pc(pc0),
        .out_alu_sel(alu0), .out_a_sel(a0), .out_b_sel(b0), .out_imm(imm0),
        .out_rs1(rs1_0), .out_rs2(rs2_0), .out_rd(rd_0),
        .out_class(cls0), .out_illegal(ill0)
    );

    assign act1 = {pc1, alu1, a1, b1, imm1, rs1_1, rs2_1, rd_1, cls1, ill1};
    assign act0 = {pc0, alu0, a0, b0, imm0, rs1_0, rs2_0, rd_0, cls0, ill0};

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Reference decoder: immediates by integer arithmetic on the word,
    // operation by table lookup on funct3 plus the documented exceptions.
    function automatic rec_t ref_dec(input logic [31:0] ins, input logic [31:0] pc);
        rec_t     r;
        alu_op_t  tbl [8];
        int       s, sgn, hi, lo;
        logic [31:0] iI, iS, iB, iU, iJ;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        bit       bad;
        tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        s   = ins;
        sgn = s >>> 31;
        hi  = s >>> 25;
        lo  = ins[11:7];
        iI  = s >>> 20;
        iS  = hi * 32 + lo;
        iB  = sgn * 4096 + ins[7] * 2048 + ins[30:25] * 32 + ins[11:8] * 2;
        iU  = {ins[31:12], 12'h000};
        iJ  = sgn * 1048576 + ins[19:12] * 4096 + ins[20] * 2048 + ins[30:21] * 2;
        bad = 0;
        r = '0;
        r.pc = pc; r.rs1 = ins[19:15]; r.rs2 = ins[24:20]; r.rd = ins[11:7];
        r.alu = ALU_ADD; r.a = SRC_A_RS1; r.b = SRC_B_RS2; r.cls = CLS_ALU;
        case (op)
            OPC_OP: begin
                if (f7 == 0) r.alu = tbl[f3];
                else if (f7 == 7'h20 && f3 == 0) r.alu = ALU_SUB;
                else if (f7 == 7'h20 && f3 == 5) r.alu = ALU_SRA;
                else bad = 1;
            end
            OPC_OP_IMM: begin
                r.b = SRC_B_IMM; r.imm = iI; r.alu = tbl[f3];
                if (f3 == 1 && f7 != 0) bad = 1;
                if (f3 == 5) begin
                    if (f7 == 7'h20) r.alu = ALU_SRA;
                    else if (f7 != 0) bad = 1;
                end
            end
            OPC_LUI:   begin r.a = SRC_A_ZERO; r.b = SRC_B_IMM; r.imm = iU; end
            OPC_AUIPC: begin r.a = SRC_A_PC;   r.b = SRC_B_IMM; r.imm = iU; end
            OPC_LOAD:  begin r.b = SRC_B_IMM; r.imm = iI; r.cls = CLS_LOAD; end
            OPC_STORE: begin r.b = SRC_B_IMM; r.imm = iS; r.cls = CLS_STORE; r.rd = 0; end
            OPC_BRANCH: begin
                r.imm = iB; r.cls = CLS_BRANCH; r.rd = 0;
                if (f3 == 0 || f3 == 1) r.alu = ALU_SUB;
                else if (f3 == 4 || f3 == 5) r.alu = ALU_SLT;
                else if (f3 == 6 || f3 == 7) r.alu = ALU_SLTU;
                else bad = 1;
            end
            OPC_JAL:  begin r.a = SRC_A_PC; r.b = SRC_B_FOUR; r.imm = iJ; r.cls = CLS_JUMP; end
            OPC_JALR: begin
                r.a = SRC_A_PC; r.b = SRC_B_FOUR; r.imm = iI; r.cls = CLS_JUMP;
                if (f3 != 0) bad = 1;
            end
            OPC_MISC_MEM, OPC_SYSTEM: begin r.alu = ALU_NOP; r.imm = iI; r.cls = CLS_SYSTEM; end
            default: bad = 1;
        endcase
        if (bad) begin
            r.alu = ALU_INVALID; r.a = 0; r.b = 0; r.imm = 0; r.cls = CLS_ALU;
            r.rd = ins[11:7]; r.ill = 1;
        end
        return r;
    endfunction

    function automatic rec_t mk(input alu_op_t alu, input src_a_sel_t a, input src_b_sel_t b,
                                input logic [31:0] imm, input int r1, input int r2, input int rd,
                                input inst_class_t c, input logic ill);
        rec_t r;
        r = '0;
        r.alu = alu; r.a = a; r.b = b; r.imm = imm;
        r.rs1 = 5'(r1); r.rs2 = 5'(r2); r.rd = 5'(rd); r.cls = c; r.ill = ill;
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  ops [11];
        int          pick;
        ops = '{OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_LOAD, OPC_STORE,
                OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM};
        w = $urandom;
        pick = $urandom_range(0, 12);
        if (pick < 11) w[6:0] = ops[pick];
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            default: ;
        endcase
        return w;
    endfunction

    // One clock: entered just after an edge with inputs already driven.
    // Checks occupancy and popped data for both instances, then updates the model.
    task automatic cycle();
        bit   x1, x0;
        rec_t e;
        #1;
        chk("in_ready", rdy1, q1.size() < 2);
        chk("out_valid", val1, q1.size() != 0);
        chk("in_ready_drop", rdy0, q0.size() < 2);
        chk("out_valid_drop", val0, q0.size() != 0);
        if (val1 && out_ready && q1.size() > 0) chk("entry", act1, q1.pop_front());
        if (val0 && out_ready && q0.size() > 0) chk("entry_drop", act0, q0.pop_front());
        x1 = in_valid && rdy1;
        x0 = in_valid && rdy0;
        e  = ref_dec(in_instr, in_pc);
        @(posedge clk);
        if (flush) begin
            q1.delete();
            q0.delete();
        end else begin
            if (x1) q1.push_back(e);
            if (x0 && !e.ill) q0.push_back(e);
        end
        last_x1 = x1;
        #1;
    endtask

    vec_t        vecs [9];
    logic [31:0] bp [4];
    int          k;

    initial begin
        vecs[0] = '{32'h40B50533, mk(ALU_SUB,     SRC_A_RS1,  SRC_B_RS2,  32'h0,        10, 11, 10, CLS_ALU,    1'b0)};
        vecs[1] = '{32'h40B55533, mk(ALU_SRA,     SRC_A_RS1,  SRC_B_RS2,  32'h0,        10, 11, 10, CLS_ALU,    1'b0)};
        vecs[2] = '{32'h02B50533, mk(ALU_INVALID, SRC_A_RS1,  SRC_B_RS2,  32'h0,        10, 11, 10, CLS_ALU,    1'b1)};
        vecs[3] = '{32'hFFF50513, mk(ALU_ADD,     SRC_A_RS1,  SRC_B_IMM,  32'hFFFFFFFF, 10, 31, 10, CLS_ALU,    1'b0)};
        vecs[4] = '{32'h123452B7, mk(ALU_ADD,     SRC_A_ZERO, SRC_B_IMM,  32'h12345000,  8,  3,  5, CLS_ALU,    1'b0)};
        vecs[5] = '{32'hFE000EE3, mk(ALU_SUB,     SRC_A_RS1,  SRC_B_RS2,  32'hFFFFFFFC,  0,  0,  0, CLS_BRANCH, 1'b0)};
        vecs[6] = '{32'h008000EF, mk(ALU_ADD,     SRC_A_PC,   SRC_B_FOUR, 32'h00000008,  0,  8,  1, CLS_JUMP,   1'b0)};
        vecs[7] = '{32'h0000007F, mk(ALU_INVALID, SRC_A_RS1,  SRC_B_RS2,  32'h0,         0,  0,  0, CLS_ALU,    1'b1)};
        vecs[8] = '{32'h00000000, mk(ALU_INVALID, SRC_A_RS1,  SRC_B_RS2,  32'h0,         0,  0,  0, CLS_ALU,    1'b1)};
        bp = '{32'h00A00093, 32'h00208133, 32'h403101B3, 32'h0041A223};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instr = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset_data", act1, '0);
        chk("reset_valid", val1, 1'b0);
        chk("reset_ready", rdy1, 1'b1);
        rst = 1'b0;
        @(posedge clk); #1;

        // directed decode table, one entry in flight at a time
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            rec_t want;
            in_valid = 1'b1; in_instr = vecs[i].instr; in_pc = 32'h1000 + 32'(i) * 4;
            cycle();
            in_valid = 1'b0;
            want = vecs[i].exp;
            want.pc = 32'h1000 + 32'(i) * 4;
            chk($sformatf("vec%0d_valid", i), val1, 1'b1);
            chk($sformatf("vec%0d", i), act1, want);
        end
        chk("illegal_dropped_valid", val0, 1'b0);
        chk("illegal_dropped_ready", rdy0, 1'b1);
        cycle();

        // backpressure: 3 stalled cycles accept only two entries
        out_ready = 1'b0; k = 0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; in_instr = bp[k]; in_pc = 32'h2000 + 32'(k) * 4;
            cycle();
            if (last_x1) k++;
        end
        chk("bp_accepted", k, 2);
        chk("bp_ready_low", rdy1, 1'b0);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (k < 4) begin
                in_valid = 1'b1; in_instr = bp[k]; in_pc = 32'h2000 + 32'(k) * 4;
            end else begin
                in_valid = 1'b0;
            end
            chk($sformatf("bp_stream%0d", c), val1, 1'b1);
            cycle();
            if (last_x1) k++;
        end
        in_valid = 1'b0;
        chk("bp_all_sent", k, 4);
        chk("bp_drained", val1, 1'b0);

        // flush in FULL with an instruction offered
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1; in_instr = bp[c]; in_pc = 32'h3000 + 32'(c) * 4;
            cycle();
        end
        chk("flush_full_ready", rdy1, 1'b0);
        flush = 1'b1; in_instr = 32'h00100513; in_pc = 32'h3100;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_full_valid", val1, 1'b0);
        chk("flush_full_ready_after", rdy1, 1'b1);
        // flush in ONE while a transfer is really accepted
        in_valid = 1'b1; in_instr = bp[2]; in_pc = 32'h3200;
        cycle();
        flush = 1'b1; in_instr = bp[3]; in_pc = 32'h3204;
        chk("flush_one_accepting", rdy1, 1'b1);
        cycle();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("flush_one_valid", val1, 1'b0);
        cycle(); cycle();
        chk("flush_no_leak", val1, 1'b0);

        // asynchronous reset while FULL
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1; in_instr = vecs[c].instr; in_pc = 32'h4000 + 32'(c) * 4;
            cycle();
        end
        in_valid = 1'b0;
        chk("pre_reset_full", rdy1, 1'b0);
        rst = 1'b1;
        #1;
        chk("midreset_valid", val1, 1'b0);
        chk("midreset_ready", rdy1, 1'b1);
        chk("midreset_alu", alu1, ALU_NOP);
        chk("midreset_data", act1, '0);
        q1.delete(); q0.delete();
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // randomized traffic against the reference model
        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            in_instr  = rand_instr();
            in_pc     = $urandom;
            cycle();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) cycle();
        chk("final_empty", q1.size() + q0.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
